// File: rtl/note_coord_picker_if.sv
// Note-in / draw-request-out bundle between the note source, the coordinate
// picker and the VGA drawer.
interface note_coord_picker_if;
    logic       clear;
    logic       ld_note;
    logic [3:0] note;
    logic [1:0] octave;
    logic       draw_ack;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       draw_req;
    logic       busy;
    logic       page_wrap;
    logic       dropped;
    logic [4:0] col;
    logic [1:0] row;

    modport master (
        output clear, ld_note, note, octave, draw_ack,
        input  x, y, colour, draw_req, busy, page_wrap, dropped, col, row
    );

    modport slave (
        input  clear, ld_note, note, octave, draw_ack,
        output x, y, colour, draw_req, busy, page_wrap, dropped, col, row
    );
endinterface

// File: rtl/note_coord_picker.sv
// Maps each accepted note to a screen slot and colour on the 160x120 display
// and holds the draw request until the drawer acknowledges it.
module note_coord_picker #(
    parameter int COLS = 18,
    parameter int ROWS = 4
) (
    input  logic               clk,
    input  logic               reset,
    note_coord_picker_if.slave bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_REQ   = 1'b1;
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
    localparam logic [3:0] NOTE_MAX  = 4'd11;
    localparam logic [3:0] NOTE_REST = 4'hF;

    logic [0:0] r_state;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic [4:0] r_col;
    logic [1:0] r_row;
    logic       r_page_wrap;
    logic       r_dropped;

    logic       w_idle;
    logic       w_req;
    logic       w_accept;
    logic       w_rest;
    logic       w_ack;
    logic       w_advance;
    logic       w_wrap;
    logic [4:0] w_col_next;
    logic [1:0] w_row_next;
    logic [7:0] w_x_slot;
    logic [6:0] w_y_slot;

    function automatic logic [2:0] octave_colour(input logic [1:0] oct);
        logic [2:0] c;
        case (oct)
            2'd0:    c = 3'b001;
            2'd1:    c = 3'b010;
            2'd2:    c = 3'b100;
            2'd3:    c = 3'b111;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    assign w_idle    = (r_state == ST_IDLE);
    assign w_req     = (r_state == ST_REQ);
    assign w_accept  = w_idle && bus.ld_note && (bus.note <= NOTE_MAX);
    assign w_rest    = w_idle && bus.ld_note && (bus.note == NOTE_REST);
    assign w_ack     = w_req && bus.draw_ack;
    assign w_advance = w_rest || w_ack;

    // Each pitch step moves the glyph 2 pixels up from the row's bottom line.
    assign w_x_slot = {r_col, 3'b000} + 8'd8;
    assign w_y_slot = 7'd26 + (7'(r_row) * 7'd30) - {2'b00, bus.note, 1'b0};

    // Next slot pointer, wrapping column into row and row into page.
    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        w_wrap     = 1'b0;
        if (r_col == LAST_COL) begin
            w_col_next = 5'd0;
            if (r_row == LAST_ROW) begin
                w_row_next = 2'd0;
                w_wrap     = 1'b1;
            end else begin
                w_row_next = r_row + 2'd1;
            end
        end else begin
            w_col_next = r_col + 5'd1;
        end
    end

    // Request state: clear abandons any pending draw.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else if (bus.clear) begin
            r_state <= ST_IDLE;
        end else if (w_accept) begin
            r_state <= ST_REQ;
        end else if (w_ack) begin
            r_state <= ST_IDLE;
        end
    end

    // Glyph position and colour, latched only when a pitched note is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x      <= 8'd8;
            r_y      <= 7'd4;
            r_colour <= 3'b000;
        end else if (!bus.clear && w_accept) begin
            r_x      <= w_x_slot;
            r_y      <= w_y_slot;
            r_colour <= octave_colour(bus.octave);
        end
    end

    // Slot pointer and the page-wrap pulse that follows its last advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col       <= 5'd0;
            r_row       <= 2'd0;
            r_page_wrap <= 1'b0;
        end else if (bus.clear) begin
            r_col       <= 5'd0;
            r_row       <= 2'd0;
            r_page_wrap <= 1'b0;
        end else begin
            r_page_wrap <= w_advance && w_wrap;
            if (w_advance) begin
                r_col <= w_col_next;
                r_row <= w_row_next;
            end
        end
    end

    // Sticky overrun flag: any note offered while a request is outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dropped <= 1'b0;
        end else if (bus.clear) begin
            r_dropped <= 1'b0;
        end else if (w_req && bus.ld_note) begin
            r_dropped <= 1'b1;
        end
    end

    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.colour    = r_colour;
    assign bus.draw_req  = w_req;
    assign bus.busy      = w_req;
    assign bus.page_wrap = r_page_wrap;
    assign bus.dropped   = r_dropped;
    assign bus.col       = r_col;
    assign bus.row       = r_row;
endmodule

// File: tb/tb_note_coord_picker.sv
// Bench for note_coord_picker: vector table, directed corner sequences and
// randomized traffic against a slot-index reference model.
module tb_note_coord_picker;
    localparam int COLS  = 18;
    localparam int ROWS  = 4;
    localparam int NSLOT = COLS * ROWS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_coord_picker_if bus();

    note_coord_picker #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       clr;
        logic       ld;
        logic [3:0] note;
        logic [1:0] oct;
        logic       ack;
        logic       req;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic [4:0] col;
        logic [1:0] row;
        logic       pw;
        logic       drop;
    } vec_t;

    vec_t vecs[15];
    logic [2:0] ctab[4];

    task automatic drive(input logic clr, input logic ld, input logic [3:0] n,
                         input logic [1:0] o, input logic ack);
        bus.clear    = clr;
        bus.ld_note  = ld;
        bus.note     = n;
        bus.octave   = o;
        bus.draw_ack = ack;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [7:0] x,
                           input logic [6:0] y, input logic [2:0] c, input logic [4:0] col,
                           input logic [1:0] row, input logic pw, input logic drop);
        chk($sformatf("%s.draw_req", tag), 32'(bus.draw_req), 32'(req));
        chk($sformatf("%s.busy", tag), 32'(bus.busy), 32'(req));
        chk($sformatf("%s.x", tag), 32'(bus.x), 32'(x));
        chk($sformatf("%s.y", tag), 32'(bus.y), 32'(y));
        chk($sformatf("%s.colour", tag), 32'(bus.colour), 32'(c));
        chk($sformatf("%s.col", tag), 32'(bus.col), 32'(col));
        chk($sformatf("%s.row", tag), 32'(bus.row), 32'(row));
        chk($sformatf("%s.page_wrap", tag), 32'(bus.page_wrap), 32'(pw));
        chk($sformatf("%s.dropped", tag), 32'(bus.dropped), 32'(drop));
    endtask

    initial begin
        int pw_seen;
        int slot;
        bit pend, drop, pw;
        logic [7:0] mx;
        logic [6:0] my;
        logic [2:0] mc;
        logic clr, ld, ack;
        logic [3:0] n;
        logic [1:0] o;

        ctab[0] = 3'b001; ctab[1] = 3'b010; ctab[2] = 3'b100; ctab[3] = 3'b111;

        //            clr   ld    note   oct   ack   req   x      y      colour  col   row   pw    drop
        vecs[0]  = '{1'b0, 1'b1, 4'd0,  2'd2, 1'b0, 1'b1, 8'd8,  7'd26, 3'b100, 5'd0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'd0,  2'd0, 1'b0, 1'b1, 8'd8,  7'd26, 3'b100, 5'd0, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0,  2'd0, 1'b1, 1'b0, 8'd8,  7'd26, 3'b100, 5'd1, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'hF,  2'd0, 1'b0, 1'b0, 8'd8,  7'd26, 3'b100, 5'd2, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'd13, 2'd1, 1'b0, 1'b0, 8'd8,  7'd26, 3'b100, 5'd2, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'd0,  2'd0, 1'b1, 1'b0, 8'd8,  7'd26, 3'b100, 5'd2, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'd3,  2'd1, 1'b0, 1'b1, 8'd24, 7'd20, 3'b010, 5'd2, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'd5,  2'd0, 1'b0, 1'b1, 8'd24, 7'd20, 3'b010, 5'd2, 2'd0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 4'd7,  2'd3, 1'b1, 1'b0, 8'd24, 7'd20, 3'b010, 5'd3, 2'd0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 8'd24, 7'd20, 3'b010, 5'd0, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'd7,  2'd3, 1'b1, 1'b1, 8'd8,  7'd12, 3'b111, 5'd0, 2'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'd2,  2'd0, 1'b1, 1'b0, 8'd8,  7'd12, 3'b111, 5'd1, 2'd0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 4'd1,  2'd0, 1'b0, 1'b0, 8'd8,  7'd12, 3'b111, 5'd0, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 4'd1,  2'd0, 1'b0, 1'b1, 8'd8,  7'd24, 3'b001, 5'd0, 2'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'd0,  2'd0, 1'b1, 1'b0, 8'd8,  7'd24, 3'b001, 5'd0, 2'd0, 1'b0, 1'b0};

        bus.clear = 1'b0; bus.ld_note = 1'b0; bus.note = 4'd0; bus.octave = 2'd0; bus.draw_ack = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk_all("reset", 1'b0, 8'd8, 7'd4, 3'b000, 5'd0, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].clr, vecs[i].ld, vecs[i].note, vecs[i].oct, vecs[i].ack);
            chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].x, vecs[i].y, vecs[i].colour,
                    vecs[i].col, vecs[i].row, vecs[i].pw, vecs[i].drop);
        end

        // Fill 71 slots, then the last slot of the page, then wrap.
        drive(1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
        pw_seen = 0;
        for (int i = 0; i < NSLOT - 1; i++) begin
            drive(1'b0, 1'b1, 4'd11, 2'd3, 1'b0);
            if (bus.page_wrap) pw_seen++;
            drive(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
            if (bus.page_wrap) pw_seen++;
        end
        chk("fill.no_early_wrap", 32'(pw_seen), 32'd0);
        chk("fill.col", 32'(bus.col), 32'd17);
        chk("fill.row", 32'(bus.row), 32'd3);
        drive(1'b0, 1'b1, 4'd11, 2'd3, 1'b0);
        chk_all("last_slot", 1'b1, 8'd144, 7'd94, 3'b111, 5'd17, 2'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        chk_all("wrap", 1'b0, 8'd144, 7'd94, 3'b111, 5'd0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
        chk("wrap.pulse_end", 32'(bus.page_wrap), 32'd0);

        // Rests to row 2 col 7, then clear coinciding with an ack.
        drive(1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
        for (int i = 0; i < 2 * COLS + 7; i++) drive(1'b0, 1'b1, 4'hF, 2'd0, 1'b0);
        chk_all("rests", 1'b0, 8'd144, 7'd94, 3'b111, 5'd7, 2'd2, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd0, 2'd1, 1'b0);
        chk_all("r2c7_req", 1'b1, 8'd64, 7'd86, 3'b010, 5'd7, 2'd2, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd3, 2'd0, 1'b0);
        chk_all("r2c7_drop", 1'b1, 8'd64, 7'd86, 3'b010, 5'd7, 2'd2, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 4'd0, 2'd0, 1'b1);
        chk_all("clear_ack", 1'b0, 8'd64, 7'd86, 3'b010, 5'd0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
        chk("clear_ack.no_wrap", 32'(bus.page_wrap), 32'd0);

        // Asynchronous reset while a request is pending.
        drive(1'b0, 1'b1, 4'hF, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 4'd4, 2'd2, 1'b0);
        chk("pre_reset.req", 32'(bus.draw_req), 32'd1);
        #2 reset = 1'b0;
        #1 chk_all("async_reset", 1'b0, 8'd8, 7'd4, 3'b000, 5'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b1, 4'd5, 2'd0, 1'b0);
        chk_all("post_reset", 1'b1, 8'd8, 7'd16, 3'b001, 5'd0, 2'd0, 1'b0, 1'b0);

        // Randomized traffic against a slot-index model.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        slot = 0; pend = 0; drop = 0; pw = 0;
        mx = 8'd8; my = 7'd4; mc = 3'b000;
        for (int c = 0; c < 1500; c++) begin
            clr = ($urandom_range(0, 59) == 0);
            ld  = ($urandom_range(0, 2) == 0);
            n   = 4'($urandom_range(0, 15));
            o   = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 2) == 0);
            drive(clr, ld, n, o, ack);
            if (clr) begin
                slot = 0; pend = 0; drop = 0; pw = 0;
            end else begin
                pw = 0;
                if (pend) begin
                    if (ld) drop = 1;
                    if (ack) begin
                        pend = 0;
                        slot = slot + 1;
                        if (slot == NSLOT) begin slot = 0; pw = 1; end
                    end
                end else if (ld && n < 4'd12) begin
                    pend = 1;
                    mx = 8'(8 + 8 * (slot % COLS));
                    my = 7'(26 + 30 * (slot / COLS) - 2 * int'(n));
                    mc = ctab[o];
                end else if (ld && n == 4'hF) begin
                    slot = slot + 1;
                    if (slot == NSLOT) begin slot = 0; pw = 1; end
                end
            end
            chk_all($sformatf("rand%0d", c), pend, mx, my, mc, 5'(slot % COLS),
                    2'(slot / COLS), pw, drop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
